// File: rtl/block_stream_pkg.sv
// block_stream_pkg: shared constants and types for the begin/end stream
// generator.
//   - opcodes for the command interface
//   - ASCII space and the upper-case mask
//   - FSM state and word-select enums
//   - word lengths, including the leading space
package block_stream_pkg;

    localparam logic [1:0] OP_BEGIN = 2'b00;
    localparam logic [1:0] OP_END   = 2'b01;
    localparam logic [1:0] OP_CLOSE = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CASE_MASK = 8'hDF;

    // Word lengths count the leading space.
    localparam logic [2:0] LEN_BEGIN = 3'd6;
    localparam logic [2:0] LEN_END   = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_CLOSE} state_t;
    typedef enum logic {W_BEGIN, W_END} word_t;

    // Command fields latched on acceptance.
    typedef struct packed {
        word_t word;
        logic  upper;
    } cmd_t;

    function automatic logic [2:0] word_len(input word_t w);
        return (w == W_BEGIN) ? LEN_BEGIN : LEN_END;
    endfunction

endpackage

// File: rtl/block_word_rom.sv
// block_word_rom: combinational character lookup for " begin" / " end".
//   word_sel : which word
//   char_idx : position in the word; index 0 is the leading space
//   upper    : fold letters to upper case
//   ch       : ASCII character
// Out-of-range indices return a space. The space is never case-modified.
module block_word_rom
    import block_stream_pkg::*;
(
    input  word_t      word_sel,
    input  logic [2:0] char_idx,
    input  logic       upper,
    output logic [7:0] ch
);

    logic [7:0] lc;

    always_comb begin
        lc = CH_SP;
        if (word_sel == W_BEGIN) begin
            case (char_idx)
                3'd1:    lc = 8'h62; // b
                3'd2:    lc = 8'h65; // e
                3'd3:    lc = 8'h67; // g
                3'd4:    lc = 8'h69; // i
                3'd5:    lc = 8'h6E; // n
                default: lc = CH_SP;
            endcase
        end else begin
            case (char_idx)
                3'd1:    lc = 8'h65; // e
                3'd2:    lc = 8'h6E; // n
                3'd3:    lc = 8'h64; // d
                default: lc = CH_SP;
            endcase
        end
        ch = (upper && (lc != CH_SP)) ? (lc & CASE_MASK) : lc;
    end

endmodule

// File: rtl/block_stream_gen.sv
// block_stream_gen: emits space-separated "begin"/"end" text, one byte per
// cycle, and tracks nesting depth so the expected checker verdict is
// available alongside the stream.
//   clk, reset (sync, active low)
//   cmd_valid/cmd_ready/cmd_op/cmd_upper : command handshake
//   out/out_valid                         : registered ASCII stream
//   depth, err (sticky), balanced         : nesting status
module block_stream_gen
    import block_stream_pkg::*;
#(
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic               cmd_upper,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic               balanced
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t             state, state_nx;
    cmd_t               cmd, cmd_nx;
    logic [2:0]         idx, idx_nx;
    logic [7:0]         out_nx;
    logic               vld_nx;
    logic [DEPTH_W-1:0] depth_nx;
    logic               err_nx;
    logic [7:0]         rom_ch;
    logic               accept;

    assign accept = cmd_valid && cmd_ready;

    block_word_rom u_rom (
        .word_sel (cmd.word),
        .char_idx (idx),
        .upper    (cmd.upper),
        .ch       (rom_ch)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd       <= '{word: W_BEGIN, upper: 1'b0};
            idx       <= '0;
            out       <= CH_SP;
            out_valid <= 1'b0;
            depth     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd       <= cmd_nx;
            idx       <= idx_nx;
            out       <= out_nx;
            out_valid <= vld_nx;
            depth     <= depth_nx;
            err       <= err_nx;
        end
    end

    // The leading space of every word is driven straight from the accepting
    // (or word-wrapping) cycle; the ROM supplies the letters from index 1.
    always_comb begin
        state_nx = state;
        cmd_nx   = cmd;
        idx_nx   = idx;
        out_nx   = CH_SP;
        vld_nx   = 1'b0;
        depth_nx = depth;
        err_nx   = err;
        case (state)
            S_IDLE: begin
                idx_nx = '0;
                if (accept) begin
                    cmd_nx.upper = cmd_upper;
                    case (cmd_op)
                        OP_BEGIN: begin
                            cmd_nx.word = W_BEGIN;
                            state_nx    = S_EMIT;
                            idx_nx      = 3'd1;
                            vld_nx      = 1'b1;
                            if (depth == DEPTH_MAX) err_nx   = 1'b1;
                            else                    depth_nx = depth + DEPTH_ONE;
                        end
                        OP_END: begin
                            cmd_nx.word = W_END;
                            state_nx    = S_EMIT;
                            idx_nx      = 3'd1;
                            vld_nx      = 1'b1;
                            if (depth == '0) err_nx   = 1'b1;
                            else             depth_nx = depth - DEPTH_ONE;
                        end
                        OP_CLOSE: begin
                            // Nothing open: accepted, no output.
                            if (depth != '0) begin
                                cmd_nx.word = W_END;
                                state_nx    = S_CLOSE;
                                idx_nx      = 3'd1;
                                vld_nx      = 1'b1;
                                depth_nx    = depth - DEPTH_ONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_EMIT: begin
                if (idx == word_len(cmd.word)) begin
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                end else begin
                    out_nx = rom_ch;
                    vld_nx = 1'b1;
                    idx_nx = idx + 3'd1;
                end
            end
            S_CLOSE: begin
                if (idx == LEN_END) begin
                    if (depth == '0) begin
                        state_nx = S_IDLE;
                        idx_nx   = '0;
                    end else begin
                        // Next " end" starts with no gap cycle.
                        vld_nx   = 1'b1;
                        idx_nx   = 3'd1;
                        depth_nx = depth - DEPTH_ONE;
                    end
                end else begin
                    out_nx = rom_ch;
                    vld_nx = 1'b1;
                    idx_nx = idx + 3'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE) && reset;
        balanced  = (depth == '0) && !err;
    end

endmodule
